// File: rtl/rob_multi_commit_if.sv
// Port bundle for the multi-commit reorder buffer: allocation, writeback, operand lookup,
// retirement, store release, branch resolution and occupancy.
interface rob_multi_commit_if #(
   parameter int IDX_W    = 4,
   parameter int COMMIT_W = 2,
   parameter int WB_PORTS = 2,
   parameter int XLEN     = 32
);
   logic                       rdy;
   logic                       flush_in;

   logic                       alloc_valid;
   logic                       alloc_ready;
   logic [IDX_W-1:0]           alloc_tag;
   logic [2:0]                 alloc_type;
   logic [XLEN-1:0]            alloc_pc;
   logic [4:0]                 alloc_dest;
   logic                       alloc_pred;
   logic                       alloc_rdy0;

   logic [WB_PORTS-1:0]        wb_valid;
   logic [WB_PORTS*IDX_W-1:0]  wb_tag;
   logic [WB_PORTS*XLEN-1:0]   wb_value;
   logic [WB_PORTS*XLEN-1:0]   wb_jpc;

   logic [IDX_W-1:0]           qa_tag;
   logic [IDX_W-1:0]           qb_tag;
   logic                       qa_ready;
   logic                       qb_ready;
   logic [XLEN-1:0]            qa_value;
   logic [XLEN-1:0]            qb_value;

   logic [COMMIT_W-1:0]        cmt_valid;
   logic [COMMIT_W*IDX_W-1:0]  cmt_tag;
   logic [COMMIT_W*5-1:0]      cmt_rd;
   logic [COMMIT_W*XLEN-1:0]   cmt_value;

   logic                       st_go;
   logic [IDX_W-1:0]           st_tag;
   logic                       redirect;
   logic [XLEN-1:0]            redirect_pc;
   logic                       bht_upd;
   logic                       bht_miss;
   logic [XLEN-1:0]            bht_pc;
   logic [IDX_W:0]             count;

   modport master (
      output rdy, flush_in,
      output alloc_valid, alloc_type, alloc_pc, alloc_dest, alloc_pred, alloc_rdy0,
      input  alloc_ready, alloc_tag,
      output wb_valid, wb_tag, wb_value, wb_jpc,
      output qa_tag, qb_tag,
      input  qa_ready, qb_ready, qa_value, qb_value,
      input  cmt_valid, cmt_tag, cmt_rd, cmt_value,
      input  st_go, st_tag, redirect, redirect_pc, bht_upd, bht_miss, bht_pc, count
   );

   modport slave (
      input  rdy, flush_in,
      input  alloc_valid, alloc_type, alloc_pc, alloc_dest, alloc_pred, alloc_rdy0,
      output alloc_ready, alloc_tag,
      input  wb_valid, wb_tag, wb_value, wb_jpc,
      input  qa_tag, qb_tag,
      output qa_ready, qb_ready, qa_value, qb_value,
      output cmt_valid, cmt_tag, cmt_rd, cmt_value,
      output st_go, st_tag, redirect, redirect_pc, bht_upd, bht_miss, bht_pc, count
   );
endinterface

// File: rtl/rob_multi_commit.sv
// Reorder buffer with in-order multi-lane retirement, head-of-queue branch resolution
// and a one-shot store release toward the store/load buffer.
module rob_multi_commit #(
   parameter int DEPTH    = 16,
   parameter int IDX_W    = 4,
   parameter int COMMIT_W = 2,
   parameter int WB_PORTS = 2,
   parameter int XLEN     = 32
) (
   input logic clk,
   input logic rst,
   rob_multi_commit_if.slave bus
);
   localparam logic [2:0] T_BRANCH = 3'd1;
   localparam logic [2:0] T_JALR   = 3'd3;
   localparam logic [2:0] T_STORE  = 3'd4;

   logic [IDX_W-1:0] head, tail;
   logic [IDX_W:0]   count;
   logic [DEPTH-1:0] valid, ready, st_issued, e_pred;
   logic [2:0]       e_type  [DEPTH];
   logic [XLEN-1:0]  e_pc    [DEPTH];
   logic [XLEN-1:0]  e_value [DEPTH];
   logic [XLEN-1:0]  e_jpc   [DEPTH];
   logic [4:0]       e_dest  [DEPTH];

   logic [IDX_W-1:0]    lane_idx [COMMIT_W];
   logic [COMMIT_W-1:0] cmt_ok;
   logic [IDX_W:0]      n_ret;
   logic                chain;
   logic                head_br, head_jalr, br_taken, br_miss;
   logic                redirect, st_go, alloc_ready, alloc_fire, flush;

   function automatic logic is_plain(input logic [2:0] t);
      return (t != T_BRANCH) && (t != T_JALR) && (t != T_STORE);
   endfunction

   for (genvar g = 0; g < COMMIT_W; g++) begin : g_lane
      assign lane_idx[g] = head + IDX_W'(g);
   end

   // Younger lanes only retire behind a plain lane-0 entry; control flow and stores go alone.
   always_comb begin
      cmt_ok = '0;
      n_ret  = '0;
      chain  = bus.rdy;
      for (int i = 0; i < COMMIT_W; i++) begin
         if (i == 0)
            chain = chain && valid[lane_idx[i]] && ready[lane_idx[i]];
         else
            chain = chain && valid[lane_idx[i]] && ready[lane_idx[i]]
                    && is_plain(e_type[lane_idx[i]]) && is_plain(e_type[lane_idx[0]]);
         cmt_ok[i] = chain;
         n_ret     = n_ret + (IDX_W+1)'(chain);
      end
   end

   always_comb begin
      bus.cmt_valid = cmt_ok;
      bus.cmt_tag   = '0;
      bus.cmt_rd    = '0;
      bus.cmt_value = '0;
      for (int i = 0; i < COMMIT_W; i++) begin
         if (cmt_ok[i]) begin
            bus.cmt_tag[i*IDX_W +: IDX_W]  = lane_idx[i];
            bus.cmt_value[i*XLEN +: XLEN]  = e_value[lane_idx[i]];
            if (e_type[lane_idx[i]] != T_BRANCH && e_type[lane_idx[i]] != T_STORE)
               bus.cmt_rd[i*5 +: 5] = e_dest[lane_idx[i]];
         end
      end
   end

   assign head_br   = cmt_ok[0] && (e_type[head] == T_BRANCH);
   assign head_jalr = cmt_ok[0] && (e_type[head] == T_JALR);
   assign br_taken  = e_value[head][0];
   assign br_miss   = head_br && (br_taken != e_pred[head]);
   assign redirect  = br_miss || head_jalr;

   always_comb begin
      bus.redirect_pc = '0;
      if (head_jalr)
         bus.redirect_pc = e_jpc[head];
      else if (br_miss)
         bus.redirect_pc = br_taken ? e_jpc[head] : e_pc[head] + XLEN'(4);
   end

   assign bus.redirect = redirect;
   assign bus.bht_upd  = head_br;
   assign bus.bht_miss = br_miss;
   assign bus.bht_pc   = head_br ? e_pc[head] : '0;

   // A store about to be discarded by an external flush must not reach memory.
   assign st_go = bus.rdy && !bus.flush_in && valid[head] && (e_type[head] == T_STORE)
                  && !ready[head] && !st_issued[head];
   assign bus.st_go  = st_go;
   assign bus.st_tag = st_go ? head : '0;

   assign alloc_ready     = (count != (IDX_W+1)'(DEPTH));
   assign alloc_fire      = bus.alloc_valid && alloc_ready;
   assign bus.alloc_ready = alloc_ready;
   assign bus.alloc_tag   = tail;
   assign bus.count       = count;
   assign flush           = bus.flush_in || redirect;

   assign bus.qa_ready = ready[bus.qa_tag];
   assign bus.qa_value = e_value[bus.qa_tag];
   assign bus.qb_ready = ready[bus.qb_tag];
   assign bus.qb_value = e_value[bus.qb_tag];

   always_ff @(posedge clk) begin
      if (rst) begin
         head      <= '0;
         tail      <= '0;
         count     <= '0;
         valid     <= '0;
         ready     <= '0;
         st_issued <= '0;
         e_pred    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            e_type[i]  <= '0;
            e_pc[i]    <= '0;
            e_value[i] <= '0;
            e_jpc[i]   <= '0;
            e_dest[i]  <= '0;
         end
      end else if (bus.rdy) begin
         if (flush) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            valid     <= '0;
            ready     <= '0;
            st_issued <= '0;
         end else begin
            // Ascending port order lets the higher port win a same-tag collision.
            for (int p = 0; p < WB_PORTS; p++) begin
               if (bus.wb_valid[p] && valid[bus.wb_tag[p*IDX_W +: IDX_W]]) begin
                  e_value[bus.wb_tag[p*IDX_W +: IDX_W]] <= bus.wb_value[p*XLEN +: XLEN];
                  e_jpc[bus.wb_tag[p*IDX_W +: IDX_W]]   <= bus.wb_jpc[p*XLEN +: XLEN];
                  ready[bus.wb_tag[p*IDX_W +: IDX_W]]   <= 1'b1;
               end
            end
            if (st_go)
               st_issued[head] <= 1'b1;
            for (int i = 0; i < COMMIT_W; i++) begin
               if (cmt_ok[i]) begin
                  valid[lane_idx[i]]     <= 1'b0;
                  ready[lane_idx[i]]     <= 1'b0;
                  st_issued[lane_idx[i]] <= 1'b0;
               end
            end
            if (alloc_fire) begin
               valid[tail]     <= 1'b1;
               ready[tail]     <= bus.alloc_rdy0;
               st_issued[tail] <= 1'b0;
               e_type[tail]    <= bus.alloc_type;
               e_pc[tail]      <= bus.alloc_pc;
               e_dest[tail]    <= bus.alloc_dest;
               e_pred[tail]    <= bus.alloc_pred;
               e_value[tail]   <= '0;
               e_jpc[tail]     <= '0;
            end
            head  <= head + n_ret[IDX_W-1:0];
            tail  <= tail + IDX_W'(alloc_fire);
            count <= count + (IDX_W+1)'(alloc_fire) - n_ret;
         end
      end
   end
endmodule

// File: tb/tb_rob_multi_commit.sv
// Bench for rob_multi_commit: directed scenarios with literal expectations, then random
// traffic compared every cycle against a program-order queue model.
module tb_rob_multi_commit;
   localparam int DEPTH = 16;
   localparam int IDX_W = 4;
   localparam int CW    = 2;
   localparam int WP    = 2;
   localparam int XLEN  = 32;

   typedef struct {
      logic [IDX_W-1:0] tag;
      int               typ;
      logic [XLEN-1:0]  pc;
      logic [4:0]       dest;
      logic             pred;
      logic             rdy;
      logic [XLEN-1:0]  val;
      logic [XLEN-1:0]  jpc;
      logic             issued;
   } ent_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   model_on = 1'b0;

   ent_t             q[$];
   logic [XLEN-1:0]  mval [DEPTH];
   logic [IDX_W-1:0] tail_m;

   rob_multi_commit_if #(.IDX_W(IDX_W), .COMMIT_W(CW), .WB_PORTS(WP), .XLEN(XLEN)) bus ();

   rob_multi_commit #(.DEPTH(DEPTH), .IDX_W(IDX_W), .COMMIT_W(CW), .WB_PORTS(WP), .XLEN(XLEN))
      dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   function automatic bit plain(input int t);
      return !(t == 1 || t == 3 || t == 4);
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Expected outputs from the program-order queue, then advance the queue as one clock edge would.
   task automatic model_cycle();
      logic [CW-1:0]       e_cv  = '0;
      logic [CW*IDX_W-1:0] e_tag = '0;
      logic [CW*5-1:0]     e_rd  = '0;
      logic [CW*XLEN-1:0]  e_val = '0;
      logic                e_redir = 1'b0, e_upd = 1'b0, e_miss = 1'b0, e_stgo = 1'b0;
      logic [XLEN-1:0]     e_rpc = '0, e_bpc = '0;
      logic [IDX_W-1:0]    e_sttag = '0;
      logic                e_qar = 1'b0, e_qbr = 1'b0;
      int                  nret = 0;
      bit                  full;
      if (bus.rdy) begin
         for (int k = 0; k < CW; k++) begin
            if (k >= q.size()) break;
            if (!q[k].rdy) break;
            if (k > 0 && !plain(q[k].typ)) break;
            e_cv[k] = 1'b1;
            e_tag[k*IDX_W +: IDX_W] = q[k].tag;
            e_rd[k*5 +: 5]          = (q[k].typ == 1 || q[k].typ == 4) ? 5'd0 : q[k].dest;
            e_val[k*XLEN +: XLEN]   = q[k].val;
            nret++;
            if (!plain(q[k].typ)) break;
         end
      end
      if (nret > 0 && q[0].typ == 1) begin
         e_upd = 1'b1;
         e_bpc = q[0].pc;
         if (q[0].val[0] != q[0].pred) begin
            e_miss  = 1'b1;
            e_redir = 1'b1;
            e_rpc   = q[0].val[0] ? q[0].jpc : q[0].pc + 32'd4;
         end
      end
      if (nret > 0 && q[0].typ == 3) begin
         e_redir = 1'b1;
         e_rpc   = q[0].jpc;
      end
      if (bus.rdy && !bus.flush_in && q.size() > 0 && q[0].typ == 4 && !q[0].rdy && !q[0].issued) begin
         e_stgo  = 1'b1;
         e_sttag = q[0].tag;
      end
      foreach (q[j]) begin
         if (q[j].tag == bus.qa_tag) e_qar = q[j].rdy;
         if (q[j].tag == bus.qb_tag) e_qbr = q[j].rdy;
      end
      full = (q.size() >= DEPTH);

      chk("cmt_valid", bus.cmt_valid, e_cv);
      chk("cmt_tag", bus.cmt_tag, e_tag);
      chk("cmt_rd", bus.cmt_rd, e_rd);
      chk("cmt_value", bus.cmt_value, e_val);
      chk("redirect", bus.redirect, e_redir);
      chk("redirect_pc", bus.redirect_pc, e_rpc);
      chk("bht_upd", bus.bht_upd, e_upd);
      chk("bht_miss", bus.bht_miss, e_miss);
      chk("bht_pc", bus.bht_pc, e_bpc);
      chk("st_go", bus.st_go, e_stgo);
      chk("st_tag", bus.st_tag, e_sttag);
      chk("alloc_ready", bus.alloc_ready, !full);
      chk("alloc_tag", bus.alloc_tag, tail_m);
      chk("count", bus.count, q.size());
      chk("qa_ready", bus.qa_ready, e_qar);
      chk("qa_value", bus.qa_value, mval[bus.qa_tag]);
      chk("qb_ready", bus.qb_ready, e_qbr);
      chk("qb_value", bus.qb_value, mval[bus.qb_tag]);

      if (bus.rdy) begin
         if (bus.flush_in || e_redir) begin
            q.delete();
            tail_m = '0;
         end else begin
            for (int p = 0; p < WP; p++) begin
               if (bus.wb_valid[p]) begin
                  foreach (q[j]) begin
                     if (q[j].tag == bus.wb_tag[p*IDX_W +: IDX_W]) begin
                        ent_t e;
                        e = q[j];
                        e.val = bus.wb_value[p*XLEN +: XLEN];
                        e.jpc = bus.wb_jpc[p*XLEN +: XLEN];
                        e.rdy = 1'b1;
                        q[j] = e;
                        mval[e.tag] = e.val;
                     end
                  end
               end
            end
            if (e_stgo) begin
               ent_t e;
               e = q[0];
               e.issued = 1'b1;
               q[0] = e;
            end
            for (int k = 0; k < nret; k++) q.delete(0);
            if (bus.alloc_valid && !full) begin
               ent_t e;
               e.tag = tail_m;
               e.typ = int'(bus.alloc_type);
               e.pc = bus.alloc_pc;
               e.dest = bus.alloc_dest;
               e.pred = bus.alloc_pred;
               e.rdy = bus.alloc_rdy0;
               e.val = '0;
               e.jpc = '0;
               e.issued = 1'b0;
               q.push_back(e);
               mval[tail_m] = '0;
               tail_m = tail_m + 1'b1;
            end
         end
      end
   endtask

   always @(negedge clk) if (model_on) model_cycle();

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_wb();
      bus.wb_valid = '0;
      bus.wb_tag   = '0;
      bus.wb_value = '0;
      bus.wb_jpc   = '0;
   endtask

   task automatic idle();
      bus.rdy = 1'b1;
      bus.flush_in = 1'b0;
      bus.alloc_valid = 1'b0;
      bus.alloc_type = '0;
      bus.alloc_pc = '0;
      bus.alloc_dest = '0;
      bus.alloc_pred = 1'b0;
      bus.alloc_rdy0 = 1'b0;
      bus.qa_tag = '0;
      bus.qb_tag = '0;
      clear_wb();
   endtask

   task automatic set_wb(input int p, input logic [IDX_W-1:0] tag, input logic [XLEN-1:0] v,
                         input logic [XLEN-1:0] jpc);
      bus.wb_valid[p] = 1'b1;
      bus.wb_tag[p*IDX_W +: IDX_W] = tag;
      bus.wb_value[p*XLEN +: XLEN] = v;
      bus.wb_jpc[p*XLEN +: XLEN] = jpc;
   endtask

   task automatic alloc(input logic [2:0] t, input logic [XLEN-1:0] pc, input logic [4:0] d,
                        input logic pred, input logic r0);
      bus.alloc_valid = 1'b1;
      bus.alloc_type = t;
      bus.alloc_pc = pc;
      bus.alloc_dest = d;
      bus.alloc_pred = pred;
      bus.alloc_rdy0 = r0;
      step();
      bus.alloc_valid = 1'b0;
   endtask

   task automatic do_flush();
      bus.flush_in = 1'b1;
      step();
      bus.flush_in = 1'b0;
   endtask

   task automatic rand_cycle(input int alloc_pct, input int wb_pct);
      int t;
      logic [31:0] r;
      bus.rdy = ($urandom_range(0, 15) != 0);
      bus.flush_in = ($urandom_range(0, 299) == 0);
      bus.alloc_valid = ($urandom_range(0, 99) < alloc_pct);
      t = $urandom_range(0, 9);
      bus.alloc_type = (t < 4) ? 3'd0 : (t < 6) ? 3'd1 : (t == 6) ? 3'd2 : (t == 7) ? 3'd3 : 3'd4;
      r = $urandom();
      bus.alloc_pc = r & 32'hFFFF_FFFC;
      bus.alloc_dest = 5'($urandom_range(0, 31));
      bus.alloc_pred = 1'($urandom_range(0, 1));
      bus.alloc_rdy0 = (bus.alloc_type == 3'd0 || bus.alloc_type == 3'd2) && ($urandom_range(0, 3) == 0);
      clear_wb();
      for (int p = 0; p < WP; p++) begin
         if (q.size() > 0 && $urandom_range(0, 99) < wb_pct) begin
            int j;
            ent_t e;
            j = $urandom_range(0, q.size() - 1);
            e = q[j];
            if (e.typ == 4 && !e.issued && $urandom_range(0, 3) != 0) continue;
            r = $urandom();
            if (e.typ == 1) r[0] = ($urandom_range(0, 3) == 0) ? ~e.pred : e.pred;
            set_wb(p, e.tag, r, $urandom() & 32'hFFFF_FFFC);
         end else if ($urandom_range(0, 19) == 0) begin
            set_wb(p, IDX_W'($urandom_range(0, DEPTH - 1)), $urandom(), $urandom());
         end
      end
      bus.qa_tag = IDX_W'($urandom_range(0, DEPTH - 1));
      bus.qb_tag = IDX_W'($urandom_range(0, DEPTH - 1));
   endtask

   initial begin
      idle();
      rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      q.delete();
      tail_m = '0;
      foreach (mval[i]) mval[i] = '0;
      model_on = 1'b1;

      chk("rst_alloc_ready", bus.alloc_ready, 1);
      chk("rst_alloc_tag", bus.alloc_tag, 0);
      chk("rst_count", bus.count, 0);
      chk("rst_cmt_valid", bus.cmt_valid, 0);
      chk("rst_redirect", bus.redirect, 0);
      chk("rst_st_go", bus.st_go, 0);

      // three ALU entries, two completed together
      alloc(3'd0, 32'h1000, 5'd1, 1'b0, 1'b0);
      chk("t1_tag1", bus.alloc_tag, 1);
      alloc(3'd0, 32'h1004, 5'd2, 1'b0, 1'b0);
      alloc(3'd0, 32'h1008, 5'd3, 1'b0, 1'b0);
      #1;
      chk("t1_count3", bus.count, 3);
      set_wb(0, 4'd0, 32'h11, 32'h0);
      set_wb(1, 4'd1, 32'h22, 32'h0);
      step();
      clear_wb();
      #1;
      chk("t1_cmt_valid", bus.cmt_valid, 2'b11);
      chk("t1_cmt_tag", bus.cmt_tag, 8'h10);
      chk("t1_cmt_rd", bus.cmt_rd, 10'h041);
      chk("t1_cmt_value", bus.cmt_value, 64'h0000_0022_0000_0011);
      step();
      chk("t1_count1", bus.count, 1);
      do_flush();
      #1;
      chk("t1_flush_count", bus.count, 0);

      // taken branch predicted not-taken
      alloc(3'd1, 32'h200, 5'd0, 1'b0, 1'b0);
      set_wb(0, 4'd0, 32'h1, 32'h100);
      step();
      clear_wb();
      #1;
      chk("t2_redirect", bus.redirect, 1);
      chk("t2_redirect_pc", bus.redirect_pc, 32'h100);
      chk("t2_bht_miss", bus.bht_miss, 1);
      chk("t2_bht_upd", bus.bht_upd, 1);
      chk("t2_bht_pc", bus.bht_pc, 32'h200);
      step();
      chk("t2_count0", bus.count, 0);
      // not-taken branch predicted taken falls through to pc+4
      alloc(3'd1, 32'h300, 5'd0, 1'b1, 1'b0);
      set_wb(0, 4'd0, 32'h0, 32'h500);
      step();
      clear_wb();
      #1;
      chk("t2b_redirect_pc", bus.redirect_pc, 32'h304);
      chk("t2b_bht_miss", bus.bht_miss, 1);
      step();
      // correctly predicted branch
      alloc(3'd1, 32'h400, 5'd0, 1'b1, 1'b0);
      set_wb(0, 4'd0, 32'h1, 32'h480);
      step();
      clear_wb();
      #1;
      chk("t2c_redirect", bus.redirect, 0);
      chk("t2c_bht_upd", bus.bht_upd, 1);
      chk("t2c_bht_miss", bus.bht_miss, 0);
      step();

      // store release then completion three cycles later
      alloc(3'd4, 32'h600, 5'd9, 1'b0, 1'b0);
      #1;
      chk("t3_st_go", bus.st_go, 1);
      chk("t3_st_tag", bus.st_tag, 1);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t3_no_second_st_go", bus.st_go, 0);
      end
      set_wb(1, 4'd1, 32'h0, 32'h0);
      step();
      clear_wb();
      #1;
      chk("t3_cmt_valid", bus.cmt_valid, 2'b01);
      chk("t3_cmt_tag", bus.cmt_tag, 8'h01);
      chk("t3_cmt_rd", bus.cmt_rd, 0);
      step();
      chk("t3_count0", bus.count, 0);
      chk("t3_st_go_after", bus.st_go, 0);

      // fill, overfill, retire two, wrap
      do_flush();
      for (int i = 0; i < DEPTH; i++) alloc(3'd0, 32'h2000 + 32'(4 * i), 5'(i), 1'b0, 1'b0);
      #1;
      chk("t4_full_ready", bus.alloc_ready, 0);
      chk("t4_full_count", bus.count, 16);
      alloc(3'd0, 32'h3000, 5'd7, 1'b0, 1'b0);
      #1;
      chk("t4_ignored_count", bus.count, 16);
      set_wb(0, 4'd0, 32'h5, 32'h0);
      set_wb(1, 4'd1, 32'h6, 32'h0);
      step();
      clear_wb();
      #1;
      chk("t4_cmt_valid", bus.cmt_valid, 2'b11);
      chk("t4_no_credit", bus.alloc_ready, 0);
      step();
      chk("t4_ready_again", bus.alloc_ready, 1);
      chk("t4_count14", bus.count, 14);
      chk("t4_tag_wrap", bus.alloc_tag, 0);
      alloc(3'd0, 32'h3004, 5'd8, 1'b0, 1'b0);
      #1;
      chk("t4_count15", bus.count, 15);
      chk("t4_tag1", bus.alloc_tag, 1);

      // writeback collision on tag 5
      do_flush();
      for (int i = 0; i < 6; i++) alloc(3'd0, 32'h4000 + 32'(4 * i), 5'(i + 10), 1'b0, 1'b0);
      set_wb(0, 4'd5, 32'hA, 32'h0);
      set_wb(1, 4'd5, 32'hB, 32'h0);
      step();
      clear_wb();
      bus.qa_tag = 4'd5;
      bus.qb_tag = 4'd4;
      #1;
      chk("t5_qa_value", bus.qa_value, 32'hB);
      chk("t5_qa_ready", bus.qa_ready, 1);
      chk("t5_qb_ready", bus.qb_ready, 0);

      // stall holds everything, including a pending flush
      set_wb(0, 4'd0, 32'h77, 32'h0);
      step();
      clear_wb();
      bus.rdy = 1'b0;
      bus.flush_in = 1'b1;
      #1;
      chk("t6_stall_cmt", bus.cmt_valid, 0);
      step();
      chk("t6_held_count", bus.count, 6);
      bus.rdy = 1'b1;
      step();
      bus.flush_in = 1'b0;
      #1;
      chk("t6_flushed_count", bus.count, 0);

      for (int n = 0; n < 4000; n++) begin
         if (((n / 500) % 2) == 1) rand_cycle(90, 15);
         else rand_cycle(50, 50);
         step();
      end
      idle();
      step();
      model_on = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
